// File: rtl/write_control_if.sv
// Trigger/handshake and RAM write-side bundle between the capture front end and write_control.
interface write_control_if;
  logic        live_rising;
  logic        live;
  logic        trigger;
  logic        read_done;
  logic        wen;
  logic [14:0] waddr;
  logic        read_start;
  logic        busy;
  logic [5:0]  pending;
  logic [15:0] n_dropped;

  modport master (
    output live_rising, live, trigger, read_done,
    input  wen, waddr, read_start, busy, pending, n_dropped
  );

  modport slave (
    input  live_rising, live, trigger, read_done,
    output wen, waddr, read_start, busy, pending, n_dropped
  );
endinterface

// File: rtl/write_control.sv
// Writes one PACKAGE_LENGTH-sample package per accepted trigger into the circular sample RAMs,
// pulses read_start when done and refuses triggers while MAX_PENDING packages are still unread.
module write_control #(
  parameter int PACKAGE_LENGTH = 518,
  parameter int MEMORY_DEPTH   = 24576,
  parameter int MAX_PENDING    = MEMORY_DEPTH / PACKAGE_LENGTH
) (
  input  logic           clk,
  input  logic           rst_n,
  write_control_if.slave bus
);
  localparam int AW = 15;
  localparam int CW = ($clog2(PACKAGE_LENGTH) > 10) ? $clog2(PACKAGE_LENGTH) : 10;
  localparam logic [CW-1:0] LAST_CNT  = CW'(PACKAGE_LENGTH - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_DEPTH - 1);
  localparam logic [AW:0]   PKG_LEN   = (AW+1)'(PACKAGE_LENGTH);
  localparam logic [AW:0]   MEM_DEPTH = (AW+1)'(MEMORY_DEPTH);
  localparam logic [5:0]    MAX_PEND  = 6'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] base;

  logic          accept;
  logic          drop;
  logic [AW-1:0] waddr_next;
  logic [AW:0]   base_sum;
  logic [AW:0]   base_next;
  logic [5:0]    pending_next;

  assign accept     = bus.trigger && bus.live && (state == IDLE) && (bus.pending < MAX_PEND);
  assign drop       = bus.trigger && !accept;
  assign waddr_next = (bus.waddr == LAST_ADDR) ? '0 : bus.waddr + 1'b1;
  assign base_sum   = {1'b0, base} + PKG_LEN;
  assign base_next  = (base_sum >= MEM_DEPTH) ? base_sum - MEM_DEPTH : base_sum;

  // read_start is only high in DONE, so a read_done in that cycle cancels the increment
  always_comb begin
    pending_next = bus.pending;
    if (bus.read_start && !bus.read_done) begin
      pending_next = bus.pending + 6'd1;
    end else if (!bus.read_start && bus.read_done && (bus.pending != 6'd0)) begin
      pending_next = bus.pending - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.live_rising) begin
      state          <= IDLE;
      cnt            <= '0;
      base           <= '0;
      bus.wen        <= 1'b0;
      bus.waddr      <= '0;
      bus.read_start <= 1'b0;
      bus.busy       <= 1'b0;
      bus.pending    <= '0;
      bus.n_dropped  <= '0;
    end else begin
      bus.read_start <= 1'b0;
      bus.pending    <= pending_next;
      if (drop && (bus.n_dropped != 16'hFFFF)) begin
        bus.n_dropped <= bus.n_dropped + 16'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= CAPTURE;
            cnt       <= '0;
            bus.wen   <= 1'b1;
            bus.waddr <= base;
            bus.busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == LAST_CNT) begin
            state          <= DONE;
            bus.wen        <= 1'b0;
            bus.read_start <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            bus.waddr <= waddr_next;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          base     <= base_next[AW-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_control.sv
// Directed bench for write_control: vector table for short-cycle behaviour, hand sequences for captures.
module tb_write_control;
  localparam int PL = 518;
  localparam int MD = 24576;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  write_control_if bus();

  write_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        lr, lv, trg, rd;
    logic        busy, wen;
    logic [5:0]  pend;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Caller has just ticked the accepting edge; returns positioned in the DONE cycle.
  task automatic capture_check(input string tag, input int base, input int drop_at, output int last);
    int bad;
    int a;
    bad  = 0;
    last = -1;
    for (int i = 0; i < PL; i++) begin
      a = base + i;
      if (a >= MD) a -= MD;
      if (bus.wen !== 1'b1 || bus.waddr !== a[14:0] || bus.busy !== 1'b1 || bus.read_start !== 1'b0)
        bad++;
      last        = int'(bus.waddr);
      bus.trigger = (i == drop_at);
      tick();
    end
    bus.trigger = 1'b0;
    chk({tag, "_write_cycles_bad"}, bad, 0);
    chk({tag, "_done_wen"}, bus.wen, 1'b0);
    chk({tag, "_done_read_start"}, bus.read_start, 1'b1);
    chk({tag, "_done_busy"}, bus.busy, 1'b1);
  endtask

  task automatic fire();
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
  endtask

  initial begin
    int last, bad, nwen, nrs, exp_drop;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'(i)};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'd5};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd5};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 16'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0};

    rst_n           = 1'b0;
    bus.live_rising = 1'b0;
    bus.live        = 1'b0;
    bus.trigger     = 1'b0;
    bus.read_done   = 1'b0;
    tick();
    tick();
    chk("rst_wen", bus.wen, 1'b0);
    chk("rst_waddr", bus.waddr, 15'd0);
    chk("rst_read_start", bus.read_start, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pending", bus.pending, 6'd0);
    chk("rst_n_dropped", bus.n_dropped, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.live_rising = vecs[i].lr;
      bus.live        = vecs[i].lv;
      bus.trigger     = vecs[i].trg;
      bus.read_done   = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      chk($sformatf("vec%0d_wen", i), bus.wen, vecs[i].wen);
      chk($sformatf("vec%0d_pending", i), bus.pending, vecs[i].pend);
      chk($sformatf("vec%0d_n_dropped", i), bus.n_dropped, vecs[i].drop);
    end
    bus.live_rising = 1'b0;
    bus.trigger     = 1'b0;
    bus.read_done   = 1'b0;
    bus.live        = 1'b1;

    // reset mid-capture
    fire();
    repeat (3) tick();
    chk("prerst_wen", bus.wen, 1'b1);
    chk("prerst_waddr", bus.waddr, 15'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_wen", bus.wen, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_waddr", bus.waddr, 15'd0);
    rst_n = 1'b1;
    tick();

    // first package with a dropped trigger during the capture
    bus.live_rising = 1'b1;
    tick();
    bus.live_rising = 1'b0;
    tick();
    fire();
    capture_check("t1", 0, 189, last);
    chk("t1_last_waddr", last, 517);
    tick();
    chk("t1_busy_after", bus.busy, 1'b0);
    chk("t1_read_start_after", bus.read_start, 1'b0);
    chk("t1_pending", bus.pending, 6'd1);
    chk("t1_n_dropped", bus.n_dropped, 16'd1);

    // earliest possible re-trigger
    fire();
    capture_check("t2", 518, -1, last);
    chk("t2_last_waddr", last, 1035);
    tick();
    chk("t2_pending", bus.pending, 6'd2);
    chk("t2_n_dropped", bus.n_dropped, 16'd1);

    fire();
    capture_check("t4a", 1036, -1, last);
    tick();
    chk("t4_pending3", bus.pending, 6'd3);
    fire();
    capture_check("t4b", 1554, -1, last);
    bus.read_done = 1'b1;
    tick();
    chk("t4_simultaneous", bus.pending, 6'd3);
    for (int k = 2; k >= 0; k--) begin
      tick();
      chk($sformatf("t4_release_to%0d", k), bus.pending, 6'(k));
    end
    tick();
    chk("t4_no_underflow", bus.pending, 6'd0);
    bus.read_done = 1'b0;

    // abort mid-capture
    fire();
    bad = 0;
    for (int i = 0; i < 289; i++) begin
      if (bus.wen !== 1'b1) bad++;
      tick();
    end
    chk("t5_pre_abort_wen_bad", bad, 0);
    bus.live_rising = 1'b1;
    bus.trigger     = 1'b1;
    tick();
    bus.live_rising = 1'b0;
    bus.trigger     = 1'b0;
    chk("t5_abort_wen", bus.wen, 1'b0);
    chk("t5_abort_busy", bus.busy, 1'b0);
    chk("t5_abort_pending", bus.pending, 6'd0);
    chk("t5_abort_n_dropped", bus.n_dropped, 16'd0);
    nwen = 0;
    nrs  = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.wen === 1'b1) nwen++;
      if (bus.read_start === 1'b1) nrs++;
      tick();
    end
    chk("t5_idle_wen", nwen, 0);
    chk("t5_no_read_start", nrs, 0);
    fire();
    capture_check("t5", 0, -1, last);
    tick();
    chk("t5_pending", bus.pending, 6'd1);

    // fill memory with trigger held high throughout
    bus.live_rising = 1'b1;
    tick();
    bus.live_rising = 1'b0;
    bus.trigger     = 1'b1;
    nwen = 0;
    nrs  = 0;
    for (int c = 0; c < 47 * 520; c++) begin
      tick();
      if (bus.wen === 1'b1) nwen++;
      if (bus.read_start === 1'b1) nrs++;
    end
    bus.trigger = 1'b0;
    chk("t3_fill_writes", nwen, 47 * PL);
    chk("t3_fill_read_starts", nrs, 47);
    chk("t3_full_pending", bus.pending, 6'd47);
    exp_drop = 47 * 520 - 47;
    chk("t3_fill_n_dropped", bus.n_dropped, exp_drop);
    fire();
    exp_drop++;
    chk("t3_full_drop", bus.n_dropped, exp_drop);
    chk("t3_full_wen", bus.wen, 1'b0);
    tick();
    chk("t3_full_busy", bus.busy, 1'b0);
    bus.read_done = 1'b1;
    tick();
    bus.read_done = 1'b0;
    chk("t3_released", bus.pending, 6'd46);
    fire();
    capture_check("t3wrap", 47 * PL, -1, last);
    chk("t3_wrap_last_waddr", last, 287);
    tick();
    chk("t3_wrap_pending", bus.pending, 6'd47);
    bus.read_done = 1'b1;
    tick();
    bus.read_done = 1'b0;
    fire();
    capture_check("t3next", 288, -1, last);
    chk("t3_next_last_waddr", last, 805);
    tick();

    // saturate the drop counter
    bus.live    = 1'b0;
    bus.trigger = 1'b1;
    while (exp_drop < 32'hFFFE) begin
      tick();
      exp_drop++;
    end
    chk("t6_near_sat", bus.n_dropped, 16'hFFFE);
    tick();
    chk("t6_sat", bus.n_dropped, 16'hFFFF);
    repeat (3) tick();
    chk("t6_sat_hold", bus.n_dropped, 16'hFFFF);
    chk("t6_no_wen", bus.wen, 1'b0);
    bus.trigger = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/write_control.md
Name: write_control

Overview:
- Producer stage directly upstream of the package read sequencer.
- On each accepted trigger, writes one package of PACKAGE_LENGTH consecutive samples into the shared 16-channel circular sample memory.
- The 16 channel RAMs share one write address; sample data is wired straight from the ADC path to the RAMs, so this block drives only the address and write enable.
- Pulses read_start once per completed package and tracks outstanding packages so that unread data is never overwritten.

Parameters:
- PACKAGE_LENGTH, 518: samples per package per channel.
- MEMORY_DEPTH, 24576: words per channel RAM; write address wraps modulo this value.
- MAX_PENDING, MEMORY_DEPTH/PACKAGE_LENGTH (=47): maximum packages resident in memory and not yet read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- live_rising  in  1  one-cycle pulse at start of live period; run-level clear
- live  in  1  level; triggers are accepted only while high
- trigger  in  1  one event per high cycle
- read_done  in  1  one-cycle pulse from the downstream stage when a package is fully read out
- wen  out  1  RAM write enable, all channels
- waddr  out  15  RAM write address
- read_start  out  1  one-cycle pulse per completed package, to the read sequencer
- busy  out  1  high while capturing, or in the DONE cycle
- pending  out  6  packages written and not yet released by read_done
- n_dropped  out  16  rejected-trigger count; saturates at 16'hFFFF

Behaviour:
- All outputs are registered.
- Priority within a cycle: rst_n low > live_rising > normal operation.
- rst_n low, at the clock edge:
  - state=IDLE, wen=0, waddr=0, read_start=0, busy=0, pending=0, n_dropped=0.
  - The internal package base address is cleared to 0.
- live_rising high: identical clear to rst_n. A capture in progress is aborted with no read_start. A trigger in the same cycle is ignored and not counted.
- States:
  - IDLE: waiting for a trigger.
  - CAPTURE: writing a package.
  - DONE: single cycle, issues read_start.
- Trigger acceptance: trigger high in cycle N is accepted when all of the following hold:
  - state=IDLE
  - live=1
  - pending < MAX_PENDING
  On acceptance, state goes to CAPTURE.
- Any other trigger-high cycle, including live=0, busy, or full, increments n_dropped by 1, saturating at 16'hFFFF.
- CAPTURE:
  - wen=1 during cycles N+1 .. N+PACKAGE_LENGTH, with waddr=base at N+1.
  - waddr increments by 1 per cycle; at MEMORY_DEPTH-1 it wraps to 0.
  - An internal counter of at least 10 bits counts the writes.
  - After the last write, state goes to DONE.
- DONE (cycle N+PACKAGE_LENGTH+1):
  - wen=0, read_start=1, pending increments.
  - base <= base+PACKAGE_LENGTH, minus MEMORY_DEPTH if the result is >= MEMORY_DEPTH. No modulo operator.
  - Next state is IDLE.
- busy is high from N+1 through N+PACKAGE_LENGTH+1. The earliest next accepted trigger is N+PACKAGE_LENGTH+2.
- pending update:
  - +1 on read_start, -1 on read_done; both in the same cycle gives no change.
  - read_done when pending=0 is ignored; pending never underflows.
- waddr holds its last value when wen=0.
- The base address sequence must match the read sequencer's init_addr sequence exactly.

Test Plan:
1. Reset then live_rising, live=1, trigger at cycle 10 -> wen high cycles 11..528, waddr 0..517, read_start pulse at cycle 529, pending=1, busy low at 530.
2. Second trigger at cycle 200 during a capture, then a third at 530 -> n_dropped=1; third capture writes waddr 518..1035; pending=2.
3. Capture 47 packages with no read_done -> pending=47; a 48th trigger is dropped (n_dropped+1, no wen). One read_done then a trigger -> accepted, writes from base 47*518=24346, waddr wraps 24575->0 after 230 writes and ends at 287; next base=288.
4. read_done and read_start in the same cycle with pending=3 -> pending stays 3; read_done with pending=0 -> stays 0.
5. live_rising at cycle 300 mid-capture -> wen=0 at 301, no read_start, pending=0, n_dropped=0; the next trigger writes from waddr 0.
6. trigger held high for 5 cycles while live=0 -> n_dropped=5, no wen; preload near 16'hFFFF and check saturation.
